// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: fixed-priority render, round-robin check/place with bounded locks.
// Define BOARD_ARB_STATS_EN to add the saturating stall_cnt output.
module board_mem_arbiter #(
  parameter int ROWS     = 20,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 30,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [2:1]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BOARD_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    S_ARB,
    S_LOCK
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       own_req, own_lock;
  logic       held, cnt_max;
  logic       xfer1, xfer2;
  logic [2:0] we_eff;
  logic [2:0] rd;
  logic       we_sel;
  logic       in_range;
  logic       xfer;
  logic       zero_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic       unused_we0;

  assign unused_we0 = we[0];
  assign we_eff     = {we[2:1], 1'b0};

  assign own_req  = owner_q ? req[2] : req[1];
  assign own_lock = owner_q ? lock[2] : lock[1];
  assign held     = (state_q == S_LOCK) && own_req && own_lock;
  assign cnt_max  = cnt_q >= CNT_W'(LOCK_MAX);

  // owner=0 is check, owner=1 is place; rr=1 means place served last
  always_comb begin
    gnt = 3'b000;
    if (held && !(cnt_max && req[0])) begin
      gnt = owner_q ? 3'b100 : 3'b010;
    end else if (held) begin
      gnt = 3'b001;
    end else if (req[0]) begin
      gnt = 3'b001;
    end else if (req[1] && req[2]) begin
      gnt = rr_q ? 3'b010 : 3'b100;
    end else if (req[1]) begin
      gnt = 3'b010;
    end else if (req[2]) begin
      gnt = 3'b100;
    end
  end

  assign xfer1 = req[1] & gnt[1];
  assign xfer2 = req[2] & gnt[2];

  always_comb begin
    state_d = S_ARB;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = '0;
    if (xfer1 || xfer2) begin
      rr_d = xfer2;
      if (xfer2 ? lock[2] : lock[1]) begin
        state_d = S_LOCK;
        if (held && (owner_q == xfer2)) begin
          cnt_d = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          owner_d = xfer2;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ARB;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    unique case (1'b1)
      gnt[0]: begin
        addr_sel = addr0;
      end
      gnt[1]: begin
        addr_sel  = addr1;
        wdata_sel = wdata1;
        we_sel    = we_eff[1];
      end
      gnt[2]: begin
        addr_sel  = addr2;
        wdata_sel = wdata2;
        we_sel    = we_eff[2];
      end
      default: begin
        addr_sel = '0;
      end
    endcase
  end

  assign in_range  = 32'(addr_sel) < ROWS;
  assign xfer      = |(req & gnt);
  assign mem_en    = xfer & in_range;
  assign mem_we    = xfer & we_sel;
  assign mem_addr  = addr_sel;
  assign mem_wdata = wdata_sel;
  assign rd        = req & gnt & ~we_eff;

  // out-of-range reads never touch the RAM, so their data is forced to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 3'b000;
      zero_q <= 1'b0;
    end else begin
      rvalid <= rd;
      zero_q <= (|rd) & ~in_range;
    end
  end

  assign rdata = zero_q ? '0 : mem_rdata;

`ifdef BOARD_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if ((|(req & ~gnt)) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural 1-cycle board RAM.
// Expected values are hand-computed per scenario.
module tb_board_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:1]  lock;
  logic [4:0]  addr0, addr1, addr2;
  logic [29:0] wdata1, wdata2;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [29:0] rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [29:0] mem_wdata;
  logic [29:0] mem_rdata;
`ifdef BOARD_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [29:0] ram [32];

  always #5 clk = ~clk;

  board_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef BOARD_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req  = 3'b000;
    we   = 3'b000;
    lock = 2'b00;
  endtask

  logic [2:0] rr_exp [4];
  logic [2:0] lk_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rr_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
    lk_exp = '{3'b100, 3'b100, 3'b100, 3'b001};
    for (int i = 0; i < 32; i++) ram[i] = '0;
    ram[7]  = 30'h1234567;
    ram[19] = 30'h0000055;
    reset  = 1'b0;
    idle();
    addr0  = '0;
    addr1  = '0;
    addr2  = '0;
    wdata1 = '0;
    wdata2 = '0;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // render read of row 7
    req   = 3'b001;
    addr0 = 5'd7;
    #1;
    chk("r_gnt", 32'(gnt), 32'h1);
    chk("r_mem_en", 32'(mem_en), 32'h1);
    chk("r_mem_addr", 32'(mem_addr), 32'd7);
    tick();
    idle();
    chk("r_rvalid", 32'(rvalid), 32'h1);
    chk("r_rdata", 32'(rdata), 32'h1234567);

    // check/place tie round-robin
    for (int i = 0; i < 4; i++) begin
      req = 3'b110;
      #1;
      chk("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
      tick();
    end
    idle();

    // check locks row 19 for read-modify-write while place waits
    req   = 3'b110;
    lock  = 2'b01;
    addr1 = 5'd19;
    addr2 = 5'd19;
    #1;
    chk("lk_rd_gnt", 32'(gnt), 32'h2);
    tick();
    chk("lk_rvalid", 32'(rvalid), 32'h2);
    chk("lk_rdata", 32'(rdata), 32'h55);
    we     = 3'b010;
    wdata1 = 30'h2AAAAAAA;
    #1;
    chk("lk_wr_gnt", 32'(gnt), 32'h2);
    chk("lk_mem_we", 32'(mem_we), 32'h1);
    tick();
    we   = 3'b000;
    lock = 2'b00;
    #1;
    chk("lk_rel_gnt", 32'(gnt), 32'h4);
    tick();
    idle();
    chk("pl_rvalid", 32'(rvalid), 32'h4);
    chk("pl_rdata", 32'(rdata), 32'h2AAAAAAA);

    // place lock broken by render after LOCK_MAX cycles
    req   = 3'b100;
    lock  = 2'b10;
    addr2 = 5'd1;
    #1;
    chk("pl_lock_gnt", 32'(gnt), 32'h4);
    tick();
    for (int i = 0; i < 4; i++) begin
      req = 3'b101;
      #1;
      chk("brk_gnt", 32'(gnt), 32'(lk_exp[i]));
      tick();
    end
    req = 3'b110;
    #1;
    chk("brk_arb_gnt", 32'(gnt), 32'h2);
    tick();
    idle();

    // out-of-range row 25 after a real read leaves stale RAM data
    req   = 3'b001;
    addr0 = 5'd7;
    tick();
    idle();
    req    = 3'b010;
    we     = 3'b010;
    addr1  = 5'd25;
    wdata1 = 30'h3FFFFFFF;
    #1;
    chk("oob_wr_gnt", 32'(gnt), 32'h2);
    chk("oob_wr_en", 32'(mem_en), 32'h0);
    tick();
    we = 3'b000;
    #1;
    chk("oob_rd_gnt", 32'(gnt), 32'h2);
    chk("oob_rd_en", 32'(mem_en), 32'h0);
    tick();
    idle();
    chk("oob_rvalid", 32'(rvalid), 32'h2);
    chk("oob_rdata", 32'(rdata), 32'h0);

    // reset during a lock with a read in flight
    req   = 3'b010;
    lock  = 2'b01;
    addr1 = 5'd7;
    #1;
    chk("rl_gnt", 32'(gnt), 32'h2);
    tick();
    chk("rl_rvalid", 32'(rvalid), 32'h2);
    #1;
    chk("rl_hold_gnt", 32'(gnt), 32'h2);
    #1;
    reset = 1'b0;
    idle();
    #1;
    chk("rl_rst_rvalid", 32'(rvalid), 32'h0);
    chk("rl_rst_gnt", 32'(gnt), 32'h0);
    tick();
    reset = 1'b1;
    req   = 3'b110;
    #1;
    chk("rl_tie_gnt", 32'(gnt), 32'h2);
    tick();
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
